// File: rtl/dwt_frame_loader_if.sv
// Sample stream and DWT-core handshake between the loader, its upstream source and the core.
// The loader takes the slave side; the upstream source and DWT core together take the master side.
interface dwt_frame_loader_if #(
  parameter int unsigned N = 8
);
  logic            s_valid;
  logic [15:0]     s_data;
  logic            s_last;
  logic            s_ready;
  logic [N*16-1:0] array_out;
  logic            dwt_start;
  logic            dwt_done;

  modport master (
    output s_valid, s_data, s_last, dwt_done,
    input  s_ready, array_out, dwt_start
  );

  modport slave (
    input  s_valid, s_data, s_last, dwt_done,
    output s_ready, array_out, dwt_start
  );
endinterface

// File: rtl/dwt_frame_loader.sv
// Ping-pong frame loader: collects N Q8.8 samples per bank and hands each full bank to a DWT core
// through a start/done level handshake.
module dwt_frame_loader #(
  parameter int unsigned N = 8
) (
  input  logic               clk,
  input  logic               rst,
  dwt_frame_loader_if.slave  sif,
  output logic               err_len,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  localparam int unsigned IdxW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StStart, StWaitDone, StRelease} state_e;

  state_e          state_q;
  logic [1:0]      full_q, full_d;
  logic            wr_bank_q, rd_bank_q;
  logic [IdxW-1:0] wr_idx_q;
  logic [N*16-1:0] bank_q [2];
  logic [N*16-1:0] array_q;
  logic            dwt_start_q;
  logic            err_len_q;
  logic [15:0]     frame_cnt_q;

  logic accept, idx_last, frame_done, release_bank, store;

  assign sif.s_ready   = ~full_q[wr_bank_q];
  assign sif.array_out = array_q;
  assign sif.dwt_start = dwt_start_q;
  assign err_len       = err_len_q;
  assign busy          = (state_q != StIdle);
  assign frame_cnt     = frame_cnt_q;

  assign accept       = sif.s_valid & sif.s_ready;
  assign idx_last     = (wr_idx_q == IdxW'(N - 1));
  assign frame_done   = accept & idx_last;
  assign release_bank = (state_q == StWaitDone) & sif.dwt_done;
  // An early s_last only aborts the partial frame; the sample itself is not kept.
  assign store        = accept & (idx_last | ~sif.s_last);

  // Set and clear always target different banks, so both apply in the same cycle.
  always_comb begin
    full_d = full_q;
    if (release_bank) full_d[rd_bank_q] = 1'b0;
    if (frame_done)   full_d[wr_bank_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      err_len_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      err_len_q <= accept & (idx_last ? ~sif.s_last : sif.s_last);
      if (accept) begin
        if (idx_last) begin
          wr_idx_q  <= '0;
          wr_bank_q <= ~wr_bank_q;
        end else if (sif.s_last) begin
          wr_idx_q  <= '0;
        end else begin
          wr_idx_q  <= wr_idx_q + 1'b1;
        end
      end
    end
  end

  // Sample storage carries no reset; clearing the full flags is what discards buffered data.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      bank_q[wr_bank_q][16*int'(wr_idx_q) +: 16] <= sif.s_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      array_q     <= '0;
      dwt_start_q <= 1'b0;
      rd_bank_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (full_q[rd_bank_q]) begin
            array_q     <= bank_q[rd_bank_q];
            dwt_start_q <= 1'b1;
            state_q     <= StStart;
          end
        end
        StStart: begin
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          if (sif.dwt_done) begin
            dwt_start_q <= 1'b0;
            rd_bank_q   <= ~rd_bank_q;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= StRelease;
          end
        end
        StRelease: begin
          if (!sif.dwt_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
